// File: rtl/apb_slave_regs.sv
// APB completer with a NUM_REGS-entry register file, fixed wait states,
// PSLVERR on out-of-range indices and a write strobe towards local logic.
module apb_slave_regs #(
  parameter int DATA_BW     = 8,
  parameter int ADDR_BW     = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_BW-1:0]           paddr,
  input  logic [DATA_BW-1:0]           pwdata,
  output logic [DATA_BW-1:0]           prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic                         wr_vld,
  output logic [ADDR_BW-1:0]           wr_idx,
  output logic [NUM_REGS*DATA_BW-1:0]  regs_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_BW:0] NUM_REGS_W = NUM_REGS[ADDR_BW:0];
  localparam logic [3:0] WAIT_W = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [ADDR_BW-1:0]   addr_l;
  logic                 write_l;
  logic [DATA_BW-1:0]   wdata_l;
  logic [DATA_BW-1:0]   regs [NUM_REGS];

  logic                 in_range;
  logic [IDX_W-1:0]     idx;
  logic                 complete;

  assign in_range = ({1'b0, addr_l} < NUM_REGS_W);
  assign idx      = addr_l[IDX_W-1:0];
  // An initiator dropping psel in the final ACCESS cycle aborts; never signal completion then.
  assign complete = (state == ACCESS) && psel && (cnt == 4'd0);

  assign pready  = complete;
  assign pslverr = complete && !in_range;
  assign prdata  = (complete && !write_l && in_range) ? regs[idx] : '0;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_BW +: DATA_BW] = regs[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_l  <= '0;
      write_l <= 1'b0;
      wdata_l <= '0;
      wr_vld  <= 1'b0;
      wr_idx  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state   <= SETUP;
            addr_l  <= paddr;
            write_l <= pwrite;
            wdata_l <= pwdata;
            cnt     <= WAIT_W;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (write_l && in_range) begin
              regs[idx] <= wdata_l;
              wr_vld    <= 1'b1;
              wr_idx    <= addr_l;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench: two completers (0 and 2 wait states) on separate selects;
// stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_apb_slave_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel0, psel2, penable, pwrite;
  logic [7:0]   paddr, pwdata;
  logic [7:0]   prdata0, prdata2, wr_idx0, wr_idx2;
  logic         pready0, pready2, pslverr0, pslverr2, wr_vld0, wr_vld2;
  logic [127:0] regs_out0, regs_out2;

  typedef struct packed {
    logic       chk;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       q0[$], q2[$];
  logic [7:0] wq0[$], wq2[$];
  exp_t       e_mon;
  logic [7:0] w_mon;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  apb_slave_regs #(.DATA_BW(8), .ADDR_BW(8), .NUM_REGS(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .wr_vld(wr_vld0), .wr_idx(wr_idx0), .regs_out(regs_out0));

  apb_slave_regs #(.DATA_BW(8), .ADDR_BW(8), .NUM_REGS(16), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready2),
    .pslverr(pslverr2), .wr_vld(wr_vld2), .wr_idx(wr_idx2), .regs_out(regs_out2));

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pready0) begin
        if (q0.size() == 0) unexpected("dut0_pready");
        else begin
          e_mon = q0.pop_front();
          check("dut0_pslverr", 128'(pslverr0), 128'(e_mon.err));
          if (e_mon.chk) check("dut0_prdata", 128'(prdata0), 128'(e_mon.data));
        end
      end
      if (pready2) begin
        if (q2.size() == 0) unexpected("dut2_pready");
        else begin
          e_mon = q2.pop_front();
          check("dut2_pslverr", 128'(pslverr2), 128'(e_mon.err));
          if (e_mon.chk) check("dut2_prdata", 128'(prdata2), 128'(e_mon.data));
        end
      end
      if (wr_vld0) begin
        if (wq0.size() == 0) unexpected("dut0_wr_vld");
        else begin
          w_mon = wq0.pop_front();
          check("dut0_wr_idx", 128'(wr_idx0), 128'(w_mon));
        end
      end
      if (wr_vld2) begin
        if (wq2.size() == 0) unexpected("dut2_wr_vld");
        else begin
          w_mon = wq2.pop_front();
          check("dut2_wr_idx", 128'(wr_idx2), 128'(w_mon));
        end
      end
    end
  end

  task automatic set_sel(input int d, input logic v);
    if (d == 0) psel0 = v;
    else psel2 = v;
  endtask

  // Called just after a rising edge; leaves the bus idle just after the edge following pready.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input int exp_cyc, input string name);
    exp_t e;
    int   cyc;
    logic rdy;
    e.chk  = !wr;
    e.data = exp_rd;
    e.err  = (a >= 8'd16);
    if (d == 0) q0.push_back(e);
    else q2.push_back(e);
    if (wr && a < 8'd16) begin
      if (d == 0) wq0.push_back(a);
      else wq2.push_back(a);
    end
    set_sel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = a ^ 8'h01;
    pwdata  = ~wd;
    cyc = 1;
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? pready0 : pready2;
      if (rdy) break;
      if (cyc >= 40) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got no pready after %0d cycles, expected %0d", name, cyc, exp_cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_cycles"}, 128'(cyc), 128'(exp_cyc));
    @(posedge clk); #1;
    set_sel(d, 1'b0);
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel0 = 1'b0;
    psel2 = 1'b0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  localparam logic [127:0] REGS_A5   = {{12{8'h00}}, 8'hA5, 24'h0};
  localparam logic [127:0] REGS_FULL = {8'hFF, {11{8'h00}}, 8'hA5, 8'h00, 8'h00, 8'h11};

  initial begin
    rst = 1'b1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outputs", {pready0, pslverr0, wr_vld0, prdata0, wr_idx0},
          {1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    check("rst_regs", regs_out0, 128'd0);

    // Reset in the middle of an ACCESS cycle of a write to index 3
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'hA5;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    check("t1_pready_access", 128'(pready0), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_pready_async", 128'(pready0), 128'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("t1_regs", regs_out0, 128'd0);
    check("t1_wr_vld", 128'(wr_vld0), 128'd0);
    rst = 1'b0;
    idle(1);

    // Zero wait states: write then read index 3
    xfer(0, 1'b1, 8'h03, 8'hA5, 8'h00, 2, "t2_wr");
    idle(1);
    check("t2_regs", regs_out0[31:24], 128'h0A5);
    xfer(0, 1'b0, 8'h03, 8'h00, 8'hA5, 2, "t2_rd");
    idle(1);

    // Two wait states: the read spans SETUP plus three ACCESS cycles
    xfer(2, 1'b1, 8'h03, 8'hA5, 8'h00, 4, "t3_wr");
    idle(1);
    xfer(2, 1'b0, 8'h03, 8'h00, 8'hA5, 4, "t3_rd");
    idle(1);

    // Out-of-range write and read
    xfer(0, 1'b1, 8'h20, 8'h55, 8'h00, 2, "t4_wr");
    idle(1);
    xfer(0, 1'b0, 8'h20, 8'h00, 8'h00, 2, "t4_rd");
    idle(2);
    check("t4_regs", regs_out0, REGS_A5);

    // ENABLE without a preceding SETUP must be ignored
    psel0 = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("ign_pready", 128'(pready0), 128'd0);
    idle(2);

    // Back-to-back writes
    xfer(0, 1'b1, 8'h00, 8'h11, 8'h00, 2, "t5_wr0");
    xfer(0, 1'b1, 8'h0F, 8'hFF, 8'h00, 2, "t5_wr15");
    idle(2);
    check("t5_reg0", regs_out0[7:0], 128'h11);
    check("t5_reg15", regs_out0[127:120], 128'hFF);
    check("t5_regs", regs_out0, REGS_FULL);

    // Abort by dropping psel in the first ACCESS cycle
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    check("t6_pready", 128'(pready2), 128'd0);
    psel2 = 1'b0; penable = 1'b0;
    idle(4);
    check("t6_reg5", regs_out2[47:40], 128'h00);
    check("t6_regs", regs_out2, REGS_A5);

    check("q0_left", 128'(q0.size()), 128'd0);
    check("q2_left", 128'(q2.size()), 128'd0);
    check("wq0_left", 128'(wq0.size()), 128'd0);
    check("wq2_left", 128'(wq2.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
